// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W  = 16;
    localparam int unsigned FETCH_INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Smallest r with 2**r >= n; sizes FIFO pointers.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries, registered count, flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop frees the slot that a same-cycle push into a full FIFO lands in.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, single outstanding imem request, prefetch FIFO.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = FETCH_ADDR_W,
    parameter int unsigned       INSTR_W   = FETCH_INSTR_W,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       PC_INC    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ins_valid,
    output logic [INSTR_W-1:0] ins_data,
    output logic [ADDR_W-1:0]  ins_pc,
    input  logic               ins_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               halt,
    output logic               halted
);

    localparam int unsigned CNT_W   = clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              issue;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    entry_t            push_entry;
    entry_t            head_entry;

    // Request and halted status are combinational views of the registered state.
    assign imem_req  = ~rst & (state == IDLE) & ~halt & ~redirect_valid & ~fifo_full;
    assign imem_addr = fetch_pc;
    assign halted    = ~rst & halt & (state == IDLE);
    assign issue     = imem_req & imem_ready;

    // A redirect discards a coincident response; the pre-redirect stream is dead.
    assign push       = ~rst & (state == WAIT) & imem_rvalid & ~redirect_valid;
    assign pop        = ins_valid & ins_ready;
    assign push_entry = '{pc: inflight_pc, instr: imem_rdata};

    assign ins_valid = ~fifo_empty;
    assign ins_data  = head_entry.instr;
    assign ins_pc    = head_entry.pc;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_VEC;
            inflight_pc <= RESET_VEC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_addr;
            state    <= ((state != IDLE) && !imem_rvalid) ? DROP : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        state       <= WAIT;
                        fetch_pc    <= fetch_pc + ADDR_W'(PC_INC);
                        inflight_pc <= fetch_pc;
                    end
                end
                WAIT, DROP: begin
                    if (imem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Protocol checks: no response without a request, and the issue rule keeps a slot free.
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
        !((state == IDLE) && imem_rvalid));
    a_push_has_room: assert property (@(posedge clk) disable iff (rst)
        push |-> (fifo_count < CNT_W'(DEPTH)) || pop);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed per-cycle vector bench for fetch_unit; the bench plays the instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        ins_valid;
    logic [15:0] ins_data;
    logic [15:0] ins_pc;
    logic        ins_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        halt = 1'b0;
    logic        halted;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W    (16),
        .INSTR_W   (16),
        .DEPTH     (4),
        .RESET_VEC (16'h0000),
        .PC_INC    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ins_valid      (ins_valid),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt           (halt),
        .halted         (halted)
    );

    // Inputs for one cycle plus the outputs expected in that same cycle.
    typedef struct {
        logic        chk;
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [15:0] rd;
        logic        ir;
        logic        rdv;
        logic [15:0] ra;
        logic        h;
        logic        req;
        logic [15:0] addr;
        logic        iv;
        logic [15:0] ipc;
        logic [15:0] idata;
        logic        hd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic c, input logic r, input logic rdy, input logic rv,
                       input logic [15:0] rd, input logic ir, input logic rdv,
                       input logic [15:0] ra, input logic h, input logic req,
                       input logic [15:0] addr, input logic iv, input logic [15:0] ipc,
                       input logic [15:0] idata, input logic hd);
        vec_t v;
        v = '{chk: c, rst: r, rdy: rdy, rv: rv, rd: rd, ir: ir, rdv: rdv, ra: ra, h: h,
              req: req, addr: addr, iv: iv, ipc: ipc, idata: idata, hd: hd};
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int row, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [15:0] rd,
                         input logic ir, input logic rdv, input logic [15:0] ra, input logic h);
        @(negedge clk);
        rst            = r;
        imem_ready     = rdy;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        ins_ready      = ir;
        redirect_valid = rdv;
        redirect_addr  = ra;
        halt           = h;
        #1;
    endtask

    initial begin
        // Memory image: instruction at address a is 16'h1000 + a.
        //  c  rst rdy rv rd       ir rdv ra       h  req addr     iv ipc      idata    hd
        add(0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        add(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        // Streaming with one-cycle memory and ready decode
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 1, 16'h1000, 1, 0, 16'h0000, 0, 0, 16'h0002, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0002, 1, 16'h0000, 16'h1000, 0);
        add(1, 0, 1, 1, 16'h1002, 1, 0, 16'h0000, 0, 0, 16'h0004, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0004, 1, 16'h0002, 16'h1002, 0);
        add(1, 0, 1, 1, 16'h1004, 1, 0, 16'h0000, 0, 0, 16'h0006, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0006, 1, 16'h0004, 16'h1004, 0);
        // Redirect to 0x0040 with the 0x0006 request in flight; its response is dropped
        add(1, 0, 1, 0, 16'h0000, 1, 1, 16'h0040, 0, 0, 16'h0008, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 1, 16'h1006, 1, 0, 16'h0000, 0, 0, 16'h0040, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 1, 16'h1040, 1, 0, 16'h0000, 0, 0, 16'h0042, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0042, 1, 16'h0040, 16'h1040, 0);
        // Reset, then fill the FIFO with decode stalled
        add(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0042, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 1, 16'h1000, 0, 0, 16'h0000, 0, 0, 16'h0002, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0002, 1, 16'h0000, 16'h1000, 0);
        add(1, 0, 1, 1, 16'h1002, 0, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h0000, 16'h1000, 0);
        add(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0004, 1, 16'h0000, 16'h1000, 0);
        add(1, 0, 1, 1, 16'h1004, 0, 0, 16'h0000, 0, 0, 16'h0006, 1, 16'h0000, 16'h1000, 0);
        add(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0006, 1, 16'h0000, 16'h1000, 0);
        add(1, 0, 1, 1, 16'h1006, 0, 0, 16'h0000, 0, 0, 16'h0008, 1, 16'h0000, 16'h1000, 0);
        add(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0008, 1, 16'h0000, 16'h1000, 0);
        add(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0008, 1, 16'h0000, 16'h1000, 0);
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0008, 1, 16'h0000, 16'h1000, 0);
        add(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0008, 1, 16'h0002, 16'h1002, 0);
        add(1, 0, 1, 1, 16'h1008, 0, 0, 16'h0000, 0, 0, 16'h000A, 1, 16'h0002, 16'h1002, 0);
        // Pop, issue 0x000A, then redirect coincident with its response and a pop
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h000A, 1, 16'h0002, 16'h1002, 0);
        add(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h000A, 1, 16'h0004, 16'h1004, 0);
        add(1, 0, 1, 1, 16'h100A, 1, 1, 16'h0080, 0, 0, 16'h000C, 1, 16'h0004, 16'h1004, 0);
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0080, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 1, 16'h1080, 1, 0, 16'h0000, 0, 0, 16'h0082, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0082, 1, 16'h0080, 16'h1080, 0);
        // Halt with a two-cycle response in flight; the response still lands
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0082, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0084, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 1, 16'h1082, 0, 0, 16'h0000, 1, 0, 16'h0084, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0084, 1, 16'h0082, 16'h1082, 1);
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0084, 1, 16'h0082, 16'h1082, 1);
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0084, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 1, 16'h1084, 1, 0, 16'h0000, 0, 0, 16'h0086, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0086, 1, 16'h0084, 16'h1084, 0);
        // Redirect to 0xFFFE while halted, then wrap to 0x0000, then mid-flight reset
        add(1, 0, 1, 0, 16'h0000, 0, 1, 16'hFFFE, 1, 0, 16'h0086, 0, 16'h0000, 16'h0000, 1);
        add(1, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 1, 16'h0FFE, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'hFFFE, 16'h0FFE, 0);
        add(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0002, 1, 16'hFFFE, 16'h0FFE, 0);
        add(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].ir, tbl[i].rdv,
                  tbl[i].ra, tbl[i].h);
            if (tbl[i].chk) begin
                check("imem_req", i, 16'(imem_req), 16'(tbl[i].req));
                check("imem_addr", i, imem_addr, tbl[i].addr);
                check("ins_valid", i, 16'(ins_valid), 16'(tbl[i].iv));
                check("halted", i, 16'(halted), 16'(tbl[i].hd));
                if (tbl[i].iv) begin
                    check("ins_pc", i, ins_pc, tbl[i].ipc);
                    check("ins_data", i, ins_data, tbl[i].idata);
                end
            end
        end

        // Halt raised after a redirect: halted waits for the dropped response.
        drive(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0);
        check("drop_issue_req", 100, 16'(imem_req), 16'd1);
        check("drop_issue_addr", 100, imem_addr, 16'h0000);
        drive(0, 1, 0, 16'h0000, 0, 1, 16'h0100, 1);
        check("drop_redir_halted", 101, 16'(halted), 16'd0);
        check("drop_redir_req", 101, 16'(imem_req), 16'd0);
        drive(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1);
        check("drop_wait_halted", 102, 16'(halted), 16'd0);
        check("drop_wait_addr", 102, imem_addr, 16'h0100);
        drive(0, 1, 1, 16'hBEEF, 0, 0, 16'h0000, 1);
        check("drop_resp_halted", 103, 16'(halted), 16'd0);
        drive(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1);
        check("drop_done_halted", 104, 16'(halted), 16'd1);
        check("drop_done_valid", 104, 16'(ins_valid), 16'd0);
        check("drop_done_req", 104, 16'(imem_req), 16'd0);
        drive(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
        check("resume_req", 105, 16'(imem_req), 16'd1);
        check("resume_addr", 105, imem_addr, 16'h0100);
        check("resume_valid", 105, 16'(ins_valid), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
